// File: rtl/muldiv_pkg.sv
// Shared types and op-decoding helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIXUP,
    DONE
  } muldiv_state_t;

  function automatic logic is_div(input muldiv_op_t op);
    return op[2];
  endfunction

  // MUL is treated as signed; its low half is identical either way.
  function automatic logic is_signed_a(input muldiv_op_t op);
    return (op == MUL) || (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_signed_b(input muldiv_op_t op);
    return (op == MUL) || (op == MULH) || (op == DIV) || (op == REM);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Operand magnitude extraction at acceptance, and sign correction plus
// high/low half selection of the raw magnitude result in FIXUP.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  muldiv_op_t      acc_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] mag_a,
  output logic [XLEN-1:0] mag_b,
  output logic            neg_a,
  output logic            neg_b,
  input  muldiv_op_t      fix_op,
  input  logic            fix_neg_a,
  input  logic            fix_neg_b,
  input  logic            fix_div_zero,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] result
);

  logic [2*XLEN-1:0] prod;

  always_comb begin
    neg_a = is_signed_a(acc_op) && a[XLEN-1];
    neg_b = is_signed_b(acc_op) && b[XLEN-1];
    mag_a = neg_a ? -a : a;
    mag_b = neg_b ? -b : b;
  end

  // hi/lo hold the product halves for multiplies, remainder/quotient for divides.
  always_comb begin
    prod = {hi, lo};
    if (fix_neg_a ^ fix_neg_b) prod = -prod;
    result = '0;
    case (fix_op)
      MUL:                 result = prod[XLEN-1:0];
      MULH, MULHSU, MULHU: result = prod[2*XLEN-1:XLEN];
      DIV, DIVU:           result = fix_div_zero ? '1 :
                                    ((fix_neg_a ^ fix_neg_b) ? -lo : lo);
      default:             result = fix_neg_a ? -hi : hi;
    endcase
  end

endmodule

// File: rtl/iterative_muldiv.sv
// Multi-cycle RV32M multiply/divide unit, one bit per cycle on operand magnitudes.
// Optional MULDIV_EARLY_OUT_EN: zero-operand multiplies and divide special cases skip BUSY.
module iterative_muldiv
  import muldiv_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  muldiv_op_t      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  muldiv_state_t    state_q, state_d;
  muldiv_op_t       op_q;
  logic [XLEN-1:0]  hi_q, lo_q, opnd_q, result_q;
  logic             neg_a_q, neg_b_q, div_zero_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept, special_in;
  logic [XLEN-1:0]  mag_a, mag_b, fix_result;
  logic             neg_a, neg_b;
  logic [XLEN-1:0]  load_hi, load_lo;
  logic [XLEN:0]    add_sum, shifted, sub_diff;
  logic [XLEN-1:0]  step_hi, step_lo;

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .acc_op      (op),
    .a           (a),
    .b           (b),
    .mag_a       (mag_a),
    .mag_b       (mag_b),
    .neg_a       (neg_a),
    .neg_b       (neg_b),
    .fix_op      (op_q),
    .fix_neg_a   (neg_a_q),
    .fix_neg_b   (neg_b_q),
    .fix_div_zero(div_zero_q),
    .hi          (hi_q),
    .lo          (lo_q),
    .result      (fix_result)
  );

  // Initial iteration registers; early-out preloads a raw result that FIXUP turns into the answer.
`ifdef MULDIV_EARLY_OUT_EN
  logic div_zero_in, overflow_in, mul_zero_in;

  always_comb begin
    div_zero_in = is_div(op) && (b == '0);
    overflow_in = ((op == DIV) || (op == REM)) &&
                  (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    mul_zero_in = !is_div(op) && ((a == '0) || (b == '0));
    special_in  = div_zero_in || overflow_in || mul_zero_in;
    load_hi     = '0;
    load_lo     = is_div(op) ? mag_a : mag_b;
    if (special_in) begin
      load_hi = div_zero_in ? mag_a : '0;
      load_lo = div_zero_in ? '1 : (overflow_in ? mag_a : '0);
    end
  end
`else
  always_comb begin
    special_in = 1'b0;
    load_hi    = '0;
    load_lo    = is_div(op) ? mag_a : mag_b;
  end
`endif

  // One shift-add (multiply) or restoring subtract-shift (divide) step.
  always_comb begin
    add_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    shifted  = {hi_q, lo_q[XLEN-1]};
    sub_diff = shifted - {1'b0, opnd_q};
    if (is_div(op_q)) begin
      if (sub_diff[XLEN]) begin
        step_hi = shifted[XLEN-1:0];
        step_lo = {lo_q[XLEN-2:0], 1'b0};
      end else begin
        step_hi = sub_diff[XLEN-1:0];
        step_lo = {lo_q[XLEN-2:0], 1'b1};
      end
    end else begin
      step_hi = add_sum[XLEN:1];
      step_lo = {add_sum[0], lo_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Flush overrides every other transition, including acceptance in IDLE.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid && !flush) begin
          accept  = 1'b1;
          state_d = special_in ? FIXUP : BUSY;
        end
      end
      BUSY:    if (cnt_q == CNT_W'(1)) state_d = FIXUP;
      FIXUP:   state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q       <= MUL;
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      result_q   <= '0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      div_zero_q <= 1'b0;
      cnt_q      <= '0;
    end else if (accept) begin
      op_q       <= op;
      neg_a_q    <= neg_a;
      neg_b_q    <= neg_b;
      div_zero_q <= is_div(op) && (b == '0);
      opnd_q     <= is_div(op) ? mag_b : mag_a;
      hi_q       <= load_hi;
      lo_q       <= load_lo;
      cnt_q      <= CNT_W'(XLEN);
    end else if ((state_q == BUSY) && !flush) begin
      hi_q  <= step_hi;
      lo_q  <= step_lo;
      cnt_q <= cnt_q - 1'b1;
    end else if ((state_q == FIXUP) && !flush) begin
      result_q <= fix_result;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_iterative_muldiv.sv
// Scoreboard bench for iterative_muldiv: directed vectors, latency, back-pressure, flush and reset.
module tb_iterative_muldiv;
  import muldiv_pkg::*;

  localparam int XLEN = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit early_en = 1'b1;
`else
  localparam bit early_en = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  muldiv_op_t      op;
  logic [XLEN-1:0] a, b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  int              checks = 0;
  int              failures = 0;
  logic [XLEN-1:0] exp_val_q[$];
  string           exp_name_q[$];

  iterative_muldiv #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, required);
    end
  endtask

  // Pops the oldest expectation whenever a result handshake is about to complete.
  task automatic monitor();
    logic [XLEN-1:0] exp_v;
    string           exp_n;
    forever begin
      @(negedge clk);
      if (reset && !flush && out_valid && out_ready) begin
        check_output("sb_has_entry", 32'(exp_val_q.size() != 0), 32'd1);
        if (exp_val_q.size() != 0) begin
          exp_v = exp_val_q.pop_front();
          exp_n = exp_name_q.pop_front();
          check_output(exp_n, result, exp_v);
        end
      end
    end
  endtask

  // Issues one op, checks acceptance, busy-time in_ready and output latency.
  task automatic apply_stimulus(input muldiv_op_t o, input logic [31:0] va,
                                input logic [31:0] vb, input logic [31:0] expv,
                                input bit special, input string name);
    int lat;
    int ready_hi;
    int exp_lat;
    exp_lat = (early_en && special) ? 2 : XLEN + 2;
    op = o; a = va; b = vb; in_valid = 1'b1;
    exp_val_q.push_back(expv);
    exp_name_q.push_back(name);
    @(negedge clk);
    check_output({name, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~va;
    b = va ^ vb ^ 32'h5A5A_A5A5;
    lat = 0;
    ready_hi = 0;
    do begin
      @(negedge clk);
      lat++;
      if (in_ready) ready_hi++;
    end while (!out_valid && lat < 200);
    check_output({name, "_latency"}, lat, exp_lat);
    check_output({name, "_busy_in_ready"}, ready_hi, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int seen;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = MUL; a = '0; b = '0;
    #2 reset = 1'b0;
    #1;
    check_output("rst_in_ready", in_ready, 1);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_result", result, 0);
    fork
      monitor();
    join_none
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    apply_stimulus(MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, "mul_7_m3");
    apply_stimulus(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulhu_max");
    apply_stimulus(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, "mulh_m1_m1");
    apply_stimulus(MULHSU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 0, "mulhsu_m1_2");
    apply_stimulus(MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, "mulh_min_min");
    apply_stimulus(MUL,    32'd0,        32'd123,      32'd0,        1, "mul_zero");
    apply_stimulus(DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 0, "div_m7_2");
    apply_stimulus(REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 0, "rem_m7_2");
    apply_stimulus(DIVU,   32'd100,      32'd7,        32'd14,       0, "divu_100_7");
    apply_stimulus(REMU,   32'd100,      32'd7,        32'd2,        0, "remu_100_7");
    apply_stimulus(DIVU,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,        0, "divu_max_max");
    apply_stimulus(DIVU,   32'd5,        32'd0,        32'hFFFF_FFFF, 1, "divu_by_zero");
    apply_stimulus(REM,    32'd5,        32'd0,        32'd5,        1, "rem_by_zero");
    apply_stimulus(DIV,    32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFF, 1, "div_neg_by_zero");
    apply_stimulus(REM,    32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 1, "rem_neg_by_zero");
    apply_stimulus(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_overflow");
    apply_stimulus(REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1, "rem_overflow");

    // Back-pressure: result held in DONE until out_ready rises.
    out_ready = 1'b0;
    op = DIVU; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    exp_val_q.push_back(32'd14);
    exp_name_q.push_back("bp_result");
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 0;
    do begin
      @(negedge clk);
      seen++;
    end while (!out_valid && seen < 200);
    check_output("bp_latency", seen, XLEN + 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("bp_out_valid_hold", out_valid, 1);
      check_output("bp_result_hold", result, 32'd14);
      check_output("bp_in_ready_low", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_output("bp_out_valid_drop", out_valid, 0);
    apply_stimulus(MUL, 32'd3, 32'd5, 32'd15, 0, "bp_next_accept");

    // Flush during BUSY cycle 10 discards the operation.
    op = DIVU; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_output("flush_busy", busy, 0);
    check_output("flush_in_ready", in_ready, 1);
    check_output("flush_out_valid", out_valid, 0);

    // Flush in IDLE blocks acceptance of a simultaneous request.
    op = MUL; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check_output("flush_idle_busy", busy, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_output("flush_no_output", seen, 0);

    // Reset asserted at BUSY cycle 20 clears outputs immediately.
    @(posedge clk); #1;
    op = DIV; a = 32'd81; b = 32'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_output("midrst_in_ready", in_ready, 1);
    check_output("midrst_out_valid", out_valid, 0);
    check_output("midrst_busy", busy, 0);
    check_output("midrst_result", result, 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    apply_stimulus(MUL, 32'd3, 32'd4, 32'd12, 0, "mul_after_reset");

    for (int i = 0; i < 100 && exp_val_q.size() != 0; i++) @(negedge clk);
    check_output("sb_drained", exp_val_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iterative_muldiv.md
Name: iterative_muldiv

Overview:
- Multi-cycle RV32M multiply/divide unit; successor to the single-cycle ALU, parametrised in datapath width.
- Sits beside the ALU in the execute stage.
- Accepts one operation through a valid/ready handshake, iterates one bit per cycle, and returns the result through a second valid/ready handshake.
- The CPU stalls its PC while the unit is busy.

Parameters:
XLEN, 32, operand/result width in bits (>= 8, power of two)
CNT_W, $clog2(XLEN)+1, iteration counter width (derived; not overridden)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = asserted)
flush  input  1  synchronous abort; discards any in-flight operation
in_valid  input  1  operation request
in_ready  output  1  unit can accept a request
op  input  3  muldiv_op_t (encoding = RV32M funct3)
a  input  XLEN  rs1 operand
b  input  XLEN  rs2 operand
out_valid  output  1  result available
out_ready  input  1  consumer takes result
result  output  XLEN  operation result
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE; in_ready=1; out_valid=0; busy=0; result=0; counter and all internal registers cleared.
- FSM states: IDLE, BUSY, FIXUP, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at edge E0: latch op, |a|, |b| and sign flags; load counter=XLEN; go to BUSY.
- BUSY:
  - One shift-add (multiply) or restoring subtract-shift (divide) step per edge.
  - Counter decrements each step; at counter==1 the step completes and the FSM moves to FIXUP.
- FIXUP:
  - Apply sign correction: negate the product/quotient/remainder as the op requires.
  - Select the high or low half; register result; go to DONE.
- DONE:
  - out_valid=1; result is held stable until out_ready.
  - On out_valid && out_ready: go to IDLE; out_valid drops the next cycle.
  - No new request is accepted in the same cycle (in_ready=0 in DONE).
- Latency: out_valid first high XLEN+2 cycles after E0. Throughput: one op per XLEN+3 cycles minimum.
- Multiply:
  - 2*XLEN-bit product computed on magnitudes.
  - MUL: low half.
  - MULH: signed×signed high half.
  - MULHSU: signed a × unsigned b, high half.
  - MULHU: unsigned high half.
- Divide, truncating toward zero:
  - Remainder sign follows the dividend.
  - Divide by zero: DIV/DIVU result = all ones; REM/REMU result = a.
  - Signed overflow (a = 1<<(XLEN-1), b = all ones, DIV/REM): quotient = a, remainder = 0.
  - Both special cases still take the full latency unless MULDIV_EARLY_OUT_EN is defined.
- flush:
  - Any state goes to IDLE on the next edge; out_valid=0; no result is delivered.
  - flush has priority over in_valid and out_ready in the same cycle.
  - flush in IDLE with in_valid set: the request is not accepted.
- Reset mid-operation: immediate return to reset values; the operation is lost.
- Operand inputs are sampled only at acceptance; later changes to them are ignored.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - Divide by zero, signed overflow, and multiply with either operand zero bypass BUSY.
  - The FSM goes from IDLE directly to FIXUP with the special result preloaded.
  - out_valid rises 2 cycles after E0.
- Undefined:
  - Fixed XLEN+2 latency for all ops; the special results are produced by the normal iteration plus FIXUP overrides.

Decomposition:
- Package muldiv_pkg:
  - typedef enum logic [2:0] muldiv_op_t: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
  - typedef enum muldiv_state_t: IDLE, BUSY, FIXUP, DONE.
  - Helper functions is_div(op) and is_signed_a/b(op).
- One sub-module: muldiv_sign_fix.
  - Combinational abs/negate and high/low selection used at acceptance and in FIXUP.
  - Parametrised by XLEN.

Test Plan (XLEN=32, fixed-latency build unless noted):
1. MUL a=7, b=0xFFFFFFFD (-3) -> result 0xFFFFFFEB; out_valid exactly 34 cycles after the accept edge; in_ready=0 throughout.
2. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
3. DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
4. DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0. With MULDIV_EARLY_OUT_EN defined: the same results, out_valid 2 cycles after accept.
5. Back-pressure: hold out_ready=0 for 5 cycles in DONE -> result and out_valid stable, in_ready=0; raise out_ready -> IDLE next cycle, a new accept is possible the cycle after.
6. Abort: flush at BUSY cycle 10 -> IDLE next edge, no out_valid. Separate run: drive reset=0 at BUSY cycle 20 -> outputs at reset values immediately; after release, MUL 3*4 -> 12.
